// File: rtl/bank_issue_arbiter_pkg.sv
// Shared types and default timing constants for the bank issue arbiter.
package bank_issue_arbiter_pkg;

    localparam int ROW_ADDR_WIDTH = 14;
    localparam int BA_BITS        = 3;

    // Default DRAM timing constraints, in controller clock cycles.
    localparam int T_RCD_DEFAULT = 4;
    localparam int T_RP_DEFAULT  = 4;
    localparam int T_RRD_DEFAULT = 2;
    localparam int CNT_W_DEFAULT = 4;

    // Encoding 0 is the idle/no-op command and is also the reset value of the output stage.
    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_ACT       = 3'd1,
        CMD_READ      = 3'd2,
        CMD_WRITE     = 3'd3,
        CMD_PRECHARGE = 3'd4
    } bank_command_t;

endpackage

// File: rtl/bank_issue_arbiter_if.sv
// Requester and issue-queue signals of the bank issue arbiter.
//
// Handshakes: requester i offers a command while req_valid[i] is high and it is
// consumed in any cycle where req_ready[i] is also high (req_ready is one-hot or zero).
// Toward the issue queue, a command moves when o_valid & i_ready are both high in the
// same cycle; while i_ready is low the o_* signals hold stable.
interface bank_issue_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import bank_issue_arbiter_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    bank_command_t             req_command [NUM_REQ];
    logic [ROW_ADDR_WIDTH-1:0] req_row     [NUM_REQ];
    logic [NUM_REQ-1:0]        req_ready;
    logic                      o_valid;
    bank_command_t             o_command;
    logic [BA_BITS-1:0]        o_bank_address;
    logic [ROW_ADDR_WIDTH-1:0] o_row_address;
    logic                      i_ready;

    // Arbiter side.
    modport slave (
        input  req_valid, req_command, req_row, i_ready,
        output req_ready, o_valid, o_command, o_bank_address, o_row_address
    );

    // Requesters plus issue queue side.
    modport master (
        output req_valid, req_command, req_row, i_ready,
        input  req_ready, o_valid, o_command, o_bank_address, o_row_address
    );

endinterface

// File: rtl/bank_issue_arbiter_bank_timer.sv
// Loadable down-counter that saturates at zero; o_zero marks the constraint as satisfied.
module bank_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority over the countdown; counting stops at zero.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bank_issue_arbiter.sv
// Round-robin arbiter feeding one timing-legal bank command per cycle into a
// one-entry output stage toward the command scheduler's issue queue.
module bank_issue_arbiter
    import bank_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int T_RCD   = T_RCD_DEFAULT,
    parameter int T_RP    = T_RP_DEFAULT,
    parameter int T_RRD   = T_RRD_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input logic                 clk1,
    input logic                 rst,
    bank_issue_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]          r_rr_ptr;
    logic                      r_valid;
    bank_command_t             r_command;
    logic [BA_BITS-1:0]        r_bank;
    logic [ROW_ADDR_WIDTH-1:0] r_row;

    logic [NUM_REQ-1:0]        w_rcd_zero;
    logic [NUM_REQ-1:0]        w_rp_zero;
    logic                      w_rrd_zero;
    logic [NUM_REQ-1:0]        w_rcd_load;
    logic [NUM_REQ-1:0]        w_rp_load;
    logic                      w_rrd_load;
    logic [NUM_REQ-1:0]        w_eligible;
    logic [2*NUM_REQ-1:0]      w_masked;
    logic                      w_found;
    logic                      w_grant;
    logic [PTR_W-1:0]          w_gnt_idx;
    logic [NUM_REQ-1:0]        w_ready;
    bank_command_t             w_gnt_cmd;
    logic [ROW_ADDR_WIDTH-1:0] w_gnt_row;

    // Timing gate per requester: ACT waits on tRP (own bank) and tRRD (global), RD/WR on tRCD.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            case (bus.req_command[i])
                CMD_ACT:             w_eligible[i] = bus.req_valid[i] & w_rp_zero[i] & w_rrd_zero;
                CMD_READ, CMD_WRITE: w_eligible[i] = bus.req_valid[i] & w_rcd_zero[i];
                default:             w_eligible[i] = bus.req_valid[i];
            endcase
        end
    end

    // Round-robin pick: duplicate the request vector, drop bits below rr_ptr, take the lowest set bit.
    always_comb begin
        w_masked  = '0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < 2 * NUM_REQ; k++) begin
            w_masked[k] = (k >= int'(r_rr_ptr)) && w_eligible[k % NUM_REQ];
        end
        for (int k = 0; k < 2 * NUM_REQ; k++) begin
            if (!w_found && w_masked[k]) begin
                w_found   = 1'b1;
                w_gnt_idx = PTR_W'(k % NUM_REQ);
            end
        end
    end

    // A grant needs a free (or draining) output stage and is suppressed during reset.
    assign w_grant   = w_found && (!r_valid || bus.i_ready) && !rst;
    assign w_gnt_cmd = bus.req_command[w_gnt_idx];
    assign w_gnt_row = bus.req_row[w_gnt_idx];

    // One-hot grant and the matching timer loads.
    always_comb begin
        w_ready    = '0;
        w_rcd_load = '0;
        w_rp_load  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant && (w_gnt_idx == PTR_W'(i))) begin
                w_ready[i]    = 1'b1;
                w_rcd_load[i] = (w_gnt_cmd == CMD_ACT);
                w_rp_load[i]  = (w_gnt_cmd == CMD_PRECHARGE);
            end
        end
    end

    assign w_rrd_load    = w_grant && (w_gnt_cmd == CMD_ACT);
    assign bus.req_ready = w_ready;

    for (genvar b = 0; b < NUM_REQ; b++) begin : g_bank
        bank_timer #(.CNT_W(CNT_W)) u_rcd (
            .clk1       (clk1),
            .rst        (rst),
            .i_load     (w_rcd_load[b]),
            .i_load_val (CNT_W'(T_RCD - 1)),
            .o_zero     (w_rcd_zero[b])
        );
        bank_timer #(.CNT_W(CNT_W)) u_rp (
            .clk1       (clk1),
            .rst        (rst),
            .i_load     (w_rp_load[b]),
            .i_load_val (CNT_W'(T_RP - 1)),
            .o_zero     (w_rp_zero[b])
        );
    end

    bank_timer #(.CNT_W(CNT_W)) u_rrd (
        .clk1       (clk1),
        .rst        (rst),
        .i_load     (w_rrd_load),
        .i_load_val (CNT_W'(T_RRD - 1)),
        .o_zero     (w_rrd_zero)
    );

    // Round-robin pointer moves just past the winner.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
        end
    end

    // Output stage: load on grant, empty on drain without refill, otherwise hold.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_command <= CMD_NOP;
            r_bank    <= '0;
            r_row     <= '0;
        end else if (w_grant) begin
            r_valid   <= 1'b1;
            r_command <= w_gnt_cmd;
            r_bank    <= BA_BITS'(w_gnt_idx);
            r_row     <= w_gnt_row;
        end else if (bus.i_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign bus.o_valid        = r_valid;
    assign bus.o_command      = r_command;
    assign bus.o_bank_address = r_bank;
    assign bus.o_row_address  = r_row;

endmodule

// File: tb/tb_bank_issue_arbiter.sv
// Self-checking bench for bank_issue_arbiter: cycle-stamped timing model plus directed scenarios.
module tb_bank_issue_arbiter;
    import bank_issue_arbiter_pkg::*;

    localparam int N     = 4;
    localparam int T_RCD = 4;
    localparam int T_RP  = 4;
    localparam int T_RRD = 2;
    localparam int W     = 3 + BA_BITS + ROW_ADDR_WIDTH;

    // ---------------- clock / reset ----------------
    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    bank_issue_arbiter_if #(.NUM_REQ(N)) bus ();

    bank_issue_arbiter #(
        .NUM_REQ (N),
        .T_RCD   (T_RCD),
        .T_RP    (T_RP),
        .T_RRD   (T_RRD),
        .CNT_W   (4)
    ) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    int                        cyc;
    int                        m_ptr;
    logic                      m_valid;
    bank_command_t             m_cmd;
    logic [BA_BITS-1:0]        m_bank;
    logic [ROW_ADDR_WIDTH-1:0] m_row;
    int                        act_at [N];
    int                        pre_at [N];
    int                        last_act;
    logic [W-1:0]              exp_q [$];

    // Values seen on the DUT in the most recent tick, for directed checks.
    logic [N-1:0]              seen_ready;
    logic                      seen_valid;
    bank_command_t             seen_cmd;
    logic [BA_BITS-1:0]        seen_bank;
    logic [ROW_ADDR_WIDTH-1:0] seen_row;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_valid  = 1'b0;
        m_cmd    = CMD_NOP;
        m_bank   = '0;
        m_row    = '0;
        last_act = -1000;
        for (int b = 0; b < N; b++) begin
            act_at[b] = -1000;
            pre_at[b] = -1000;
        end
        exp_q.delete();
    endtask

    // A command is legal once enough cycles have passed since the relevant earlier grant.
    function automatic bit eligible(input int i);
        if (!bus.req_valid[i]) return 1'b0;
        case (bus.req_command[i])
            CMD_ACT:             return (cyc >= pre_at[i] + T_RP) && (cyc >= last_act + T_RRD);
            CMD_READ, CMD_WRITE: return cyc >= act_at[i] + T_RCD;
            default:             return 1'b1;
        endcase
    endfunction

    // ---------------- driver helpers ----------------
    task automatic clear();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]   = 1'b0;
            bus.req_command[i] = CMD_NOP;
            bus.req_row[i]     = '0;
        end
    endtask

    task automatic put(input int i, input bank_command_t c);
        bus.req_valid[i]   = 1'b1;
        bus.req_command[i] = c;
        bus.req_row[i]     = ROW_ADDR_WIDTH'($urandom_range(0, 16383));
    endtask

    // One cycle: inputs were set at the preceding negedge; compare, then advance the model.
    task automatic tick();
        logic [N-1:0] exp_ready;
        int           exp_idx;
        int           idx;
        #1;
        exp_ready = '0;
        exp_idx   = -1;
        if (!rst && (!m_valid || bus.i_ready)) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (exp_idx < 0 && eligible(idx)) exp_idx = idx;
            end
        end
        if (exp_idx >= 0) exp_ready[exp_idx] = 1'b1;

        seen_ready = bus.req_ready;
        seen_valid = bus.o_valid;
        seen_cmd   = bus.o_command;
        seen_bank  = bus.o_bank_address;
        seen_row   = bus.o_row_address;

        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("o_valid", 32'(bus.o_valid), 32'(m_valid));
        if (m_valid) begin
            check("o_command", 32'(bus.o_command), 32'(m_cmd));
            check("o_bank_address", 32'(bus.o_bank_address), 32'(m_bank));
            check("o_row_address", 32'(bus.o_row_address), 32'(m_row));
            if (bus.i_ready && exp_q.size() > 0) begin
                check("transfer", 32'({bus.o_command, bus.o_bank_address, bus.o_row_address}),
                      32'(exp_q[0]));
            end
        end

        @(posedge clk1);
        if (rst) begin
            model_reset();
        end else begin
            if (m_valid && bus.i_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_idx >= 0) begin
                m_valid = 1'b1;
                m_cmd   = bus.req_command[exp_idx];
                m_bank  = BA_BITS'(exp_idx);
                m_row   = bus.req_row[exp_idx];
                m_ptr   = (exp_idx + 1) % N;
                if (m_cmd == CMD_ACT) begin
                    act_at[exp_idx] = cyc;
                    last_act        = cyc;
                end
                if (m_cmd == CMD_PRECHARGE) pre_at[exp_idx] = cyc;
                exp_q.push_back({m_cmd, m_bank, m_row});
            end else if (bus.i_ready) begin
                m_valid = 1'b0;
            end
        end
        cyc++;
        @(negedge clk1);
    endtask

    task automatic do_reset();
        clear();
        bus.i_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int                        n;
        logic [ROW_ADDR_WIDTH-1:0] r0;
        bank_command_t             c;

        cyc = 0;
        model_reset();
        clear();
        bus.i_ready = 1'b1;
        @(negedge clk1);

        // Reset state, then all-RD round robin.
        do_reset();
        tick();
        check("rst_o_valid", 32'(seen_valid), 32'd0);
        check("rst_o_command", 32'(seen_cmd), 32'd0);
        check("rst_o_bank", 32'(seen_bank), 32'd0);
        check("rst_o_row", 32'(seen_row), 32'd0);
        check("rst_req_ready", 32'(seen_ready), 32'd0);
        for (int i = 0; i < N; i++) put(i, CMD_READ);
        for (int t = 0; t < 6; t++) begin
            tick();
            if (t < 5) check("rr_grant", 32'(seen_ready), 32'(1 << (t % 4)));
            if (t >= 1) check("rr_bank", 32'(seen_bank), 32'((t - 1) % 4));
        end

        // ACT bank 1 then RD bank 1: RD waits exactly T_RCD cycles.
        do_reset();
        clear();
        put(1, CMD_ACT);
        tick();
        check("rcd_act_grant", 32'(seen_ready), 32'b0010);
        clear();
        put(1, CMD_READ);
        n = 0;
        seen_ready = '0;
        while (!seen_ready[1] && n < 20) begin
            tick();
            n++;
        end
        check("rcd_wait", 32'(n), 32'(T_RCD));
        clear();
        tick();
        check("rcd_o_command", 32'(seen_cmd), 32'(CMD_READ));

        // Two ACTs: second one T_RRD cycles later.
        do_reset();
        clear();
        put(0, CMD_ACT);
        put(2, CMD_ACT);
        tick();
        check("rrd_first", 32'(seen_ready), 32'b0001);
        clear();
        put(2, CMD_ACT);
        tick();
        check("rrd_gap", 32'(seen_ready), 32'b0000);
        tick();
        check("rrd_second", 32'(seen_ready), 32'b0100);

        // PRE bank 3, ACT bank 3 after T_RP; RD on bank 1 still flows meanwhile.
        do_reset();
        clear();
        put(3, CMD_PRECHARGE);
        tick();
        check("rp_pre", 32'(seen_ready), 32'b1000);
        clear();
        put(3, CMD_ACT);
        put(1, CMD_READ);
        tick();
        check("rp_other_rd", 32'(seen_ready), 32'b0010);
        bus.req_valid[1] = 1'b0;
        tick();
        check("rp_wait1", 32'(seen_ready), 32'b0000);
        tick();
        check("rp_wait2", 32'(seen_ready), 32'b0000);
        tick();
        check("rp_act", 32'(seen_ready), 32'b1000);

        // Stall: i_ready low for 5 cycles keeps the stage frozen and blocks grants.
        do_reset();
        clear();
        put(0, CMD_READ);
        r0 = bus.req_row[0];
        tick();
        bus.i_ready = 1'b0;
        for (int i = 0; i < N; i++) put(i, CMD_READ);
        for (int t = 0; t < 5; t++) begin
            tick();
            check("stall_ready", 32'(seen_ready), 32'd0);
            check("stall_valid", 32'(seen_valid), 32'd1);
            check("stall_bank", 32'(seen_bank), 32'd0);
            check("stall_row", 32'(seen_row), 32'(r0));
        end
        bus.i_ready = 1'b1;
        tick();
        check("stall_release", 32'(seen_ready), 32'b0010);

        // Reset mid-transfer with tRCD pending on bank 1.
        do_reset();
        clear();
        put(1, CMD_ACT);
        tick();
        clear();
        put(0, CMD_READ);
        put(1, CMD_READ);
        rst = 1'b1;
        tick();
        check("rst_ready_low", 32'(seen_ready), 32'd0);
        rst = 1'b0;
        clear();
        put(1, CMD_READ);
        tick();
        check("post_rst_valid", 32'(seen_valid), 32'd0);
        check("post_rst_cmd", 32'(seen_cmd), 32'd0);
        check("post_rst_bank", 32'(seen_bank), 32'd0);
        check("post_rst_row", 32'(seen_row), 32'd0);
        check("post_rst_rd", 32'(seen_ready), 32'b0010);

        // Randomized traffic against the model.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            rst         = ($urandom_range(0, 299) == 0);
            bus.i_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0:       c = CMD_ACT;
                    1:       c = CMD_READ;
                    2:       c = CMD_WRITE;
                    3:       c = CMD_PRECHARGE;
                    4:       c = CMD_NOP;
                    default: c = bank_command_t'(3'd5);
                endcase
                put(i, c);
                bus.req_valid[i] = ($urandom_range(0, 2) != 0);
            end
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
